pl_cu: RTL and testbench

Parametrised pipelined control unit for the five-stage MIPS-subset CPU, sitting in ID. It decodes the ALU/immediate/branch/jump subset plus the `cont` op and a new multi-cycle multiply/divide group. It adds internal state over the previous unit: a registered branch-flush bubble, a multiply/divide busy sequencer that stalls dependent instructions, and EXE/MEM forwarding selects.

---
 rtl/pl_cu_pkg.sv | 66 ++++++
 rtl/pl_cu_md_seq.sv | 56 +++++
 rtl/pl_cu.sv | 166 ++++++++++++++++
 tb/tb_pl_cu.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/pl_cu_pkg.sv
// Shared encodings for the pipelined control unit: opcodes, func codes,
// ALU ops, next-PC selects, forwarding selects and MDU op codes.
package cu_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_CONT  = 6'b000001;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_AND  = 4'b0001;
    localparam logic [3:0] ALU_XOR  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_LUI  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_CONT = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1111;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_JR  = 2'd2;
    localparam logic [1:0] PC_JMP = 2'd3;

    localparam logic [1:0] FWD_RF   = 2'd0;
    localparam logic [1:0] FWD_EXE  = 2'd1;
    localparam logic [1:0] FWD_MEM  = 2'd2;
    localparam logic [1:0] FWD_MEML = 2'd3;

    localparam logic [1:0] MD_MULT  = 2'd0;
    localparam logic [1:0] MD_MULTU = 2'd1;
    localparam logic [1:0] MD_DIV   = 2'd2;
    localparam logic [1:0] MD_DIVU  = 2'd3;

    // Counter must hold N-1 for the larger of the two busy times, never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction
endpackage

// File: rtl/pl_cu_md_seq.sv
// Multiply/divide busy sequencer: IDLE/BUSY FSM with a down-counter that
// holds BUSY for MUL_CYCLES or DIV_CYCLES cycles after a launch pulse.
module md_seq
    import cu_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 33
) (
    input  logic clock,
    input  logic resetn,
    input  logic start_i,
    input  logic is_div_i,
    output logic busy_o
);
    localparam int CW = cnt_width(MUL_CYCLES, DIV_CYCLES);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_q <= BUSY;
                        busy_q  <= 1'b1;
                        cnt_q   <= is_div_i ? DIV_LOAD : MUL_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
endmodule

// File: rtl/pl_cu.sv
// ID-stage control unit: decode, load-use/RAW stall, branch-flush bubble,
// MDU sequencing and EXE/MEM forwarding selects (forwarding under CU_FORWARD_EN).
module pl_cu
    import cu_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 33
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       is_zero,
    input  logic       EXE_wreg,
    input  logic       EXE_m2reg,
    input  logic [4:0] EXE_rn,
    input  logic       MEM_wreg,
    input  logic       MEM_m2reg,
    input  logic [4:0] MEM_rn,
    output logic       wreg,
    output logic       wmem,
    output logic       m2reg,
    output logic       shift,
    output logic       aluimm,
    output logic       sext,
    output logic       regrt,
    output logic       jal,
    output logic [3:0] aluc,
    output logic [1:0] pcsource,
    output logic       stall,
    output logic       wpcir,
    output logic [1:0] fwda,
    output logic [1:0] fwdb,
    output logic       md_start,
    output logic [1:0] md_op,
    output logic       md_busy,
    output logic       mfhi,
    output logic       mflo
);
    logic r;
    logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_cont, i_jr;
    logic i_mfhi, i_mflo, i_md, i_div;
    logic i_addi, i_andi, i_ori, i_xori, i_lui, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
    logic use_rs, use_rt, rs_exe, rt_exe, rs_mem, rt_mem;
    logic hz_stall, md_stall, nostall;
    logic bubble_q, bubble_d;
    logic [1:0] pcs_raw;

    assign r      = (op == OP_RTYPE);
    assign i_add  = r & (func == F_ADD);
    assign i_sub  = r & (func == F_SUB);
    assign i_and  = r & (func == F_AND);
    assign i_or   = r & (func == F_OR);
    assign i_xor  = r & (func == F_XOR);
    assign i_sll  = r & (func == F_SLL);
    assign i_srl  = r & (func == F_SRL);
    assign i_sra  = r & (func == F_SRA);
    assign i_cont = r & (func == F_CONT);
    assign i_jr   = r & (func == F_JR);
    assign i_mfhi = r & (func == F_MFHI);
    assign i_mflo = r & (func == F_MFLO);
    assign i_md   = r & (func[5:2] == F_MULT[5:2]);
    assign i_div  = func[1];
    assign i_addi = (op == OP_ADDI);
    assign i_andi = (op == OP_ANDI);
    assign i_ori  = (op == OP_ORI);
    assign i_xori = (op == OP_XORI);
    assign i_lui  = (op == OP_LUI);
    assign i_lw   = (op == OP_LW);
    assign i_sw   = (op == OP_SW);
    assign i_beq  = (op == OP_BEQ);
    assign i_bne  = (op == OP_BNE);
    assign i_j    = (op == OP_J);
    assign i_jal  = (op == OP_JAL);

    assign use_rs = i_add | i_sub | i_and | i_or | i_xor | i_cont | i_jr | i_md |
                    i_addi | i_andi | i_ori | i_xori | i_lw | i_sw | i_beq | i_bne;
    assign use_rt = i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra |
                    i_cont | i_sw | i_beq | i_bne | i_md;

    // Register 0 is hard-wired, so a write to it is never a dependency.
    assign rs_exe = EXE_wreg & (EXE_rn != 5'd0) & (EXE_rn == ID_rs);
    assign rt_exe = EXE_wreg & (EXE_rn != 5'd0) & (EXE_rn == ID_rt);
    assign rs_mem = MEM_wreg & (MEM_rn != 5'd0) & (MEM_rn == ID_rs);
    assign rt_mem = MEM_wreg & (MEM_rn != 5'd0) & (MEM_rn == ID_rt);

`ifdef CU_FORWARD_EN
    function automatic logic [1:0] fwd_sel(input logic exe_hit, input logic mem_hit);
        if (exe_hit & ~EXE_m2reg) return FWD_EXE;
        if (mem_hit)              return MEM_m2reg ? FWD_MEML : FWD_MEM;
        return FWD_RF;
    endfunction

    assign hz_stall = EXE_wreg & EXE_m2reg & ((use_rs & rs_exe) | (use_rt & rt_exe));
    assign fwda     = fwd_sel(rs_exe, rs_mem);
    assign fwdb     = fwd_sel(rt_exe, rt_mem);
`else
    logic unused_m2reg;
    assign unused_m2reg = EXE_m2reg ^ MEM_m2reg;
    assign hz_stall = (use_rs & (rs_exe | rs_mem)) | (use_rt & (rt_exe | rt_mem));
    assign fwda     = FWD_RF;
    assign fwdb     = FWD_RF;
`endif

    assign md_stall = md_busy & (i_mfhi | i_mflo | i_md);
    assign stall    = hz_stall | md_stall;
    assign wpcir    = ~stall;
    assign nostall  = ~stall & ~bubble_q;

    always_comb begin
        pcs_raw = PC_SEQ;
        if ((i_beq & is_zero) | (i_bne & ~is_zero)) pcs_raw = PC_BR;
        else if (i_jr)                              pcs_raw = PC_JR;
        else if (i_j | i_jal)                       pcs_raw = PC_JMP;
    end

    always_comb begin
        aluc = ALU_ADD;
        if (i_sub | i_beq | i_bne)    aluc = ALU_SUB;
        else if (i_and | i_andi)      aluc = ALU_AND;
        else if (i_or | i_ori)        aluc = ALU_OR;
        else if (i_xor | i_xori)      aluc = ALU_XOR;
        else if (i_lui)               aluc = ALU_LUI;
        else if (i_sll)               aluc = ALU_SLL;
        else if (i_srl)               aluc = ALU_SRL;
        else if (i_sra)               aluc = ALU_SRA;
        else if (i_cont)              aluc = ALU_CONT;
    end

    assign wreg = nostall & (i_add | i_sub | i_and | i_or | i_xor | i_sll | i_srl | i_sra |
                  i_cont | i_addi | i_andi | i_ori | i_xori | i_lw | i_lui | i_jal |
                  i_mfhi | i_mflo);
    assign wmem     = nostall & i_sw;
    assign jal      = nostall & i_jal;
    assign md_start = nostall & i_md;
    assign pcsource = nostall ? pcs_raw : PC_SEQ;
    assign m2reg    = i_lw;
    assign shift    = i_sll | i_srl | i_sra;
    assign aluimm   = i_addi | i_andi | i_ori | i_xori | i_lw | i_lui | i_sw;
    assign sext     = i_addi | i_lw | i_sw | i_beq | i_bne;
    assign regrt    = i_addi | i_andi | i_ori | i_xori | i_lw | i_lui;
    assign md_op    = func[1:0];
    assign mfhi     = i_mfhi;
    assign mflo     = i_mflo;

    // A taken branch/jump squashes the instruction fetched behind it.
    assign bubble_d = |pcsource;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) bubble_q <= 1'b0;
        else         bubble_q <= bubble_d;
    end

    md_seq #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES)
    ) u_md_seq (
        .clock    (clock),
        .resetn   (resetn),
        .start_i  (md_start),
        .is_div_i (i_div),
        .busy_o   (md_busy)
    );
endmodule

// File: tb/tb_pl_cu.sv
// Scoreboard bench for pl_cu: each cycle's expected controls are queued when
// the ID/EXE/MEM inputs are driven and compared against the DUT one tick later.
module tb_pl_cu;
    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic [5:0] op = '0, func = '0;
    logic [4:0] ID_rs = '0, ID_rt = '0, EXE_rn = '0, MEM_rn = '0;
    logic       is_zero = 1'b0, EXE_wreg = 1'b0, EXE_m2reg = 1'b0, MEM_wreg = 1'b0, MEM_m2reg = 1'b0;
    logic       wreg, wmem, m2reg, shift, aluimm, sext, regrt, jal, stall, wpcir;
    logic       md_start, md_busy, mfhi, mflo;
    logic [3:0] aluc;
    logic [1:0] pcsource, fwda, fwdb, md_op;

    int checks = 0;
    int failures = 0;
    int step_no = 0;

    typedef struct packed {
        logic       stall;
        logic       wreg;
        logic       wmem;
        logic [3:0] aluc;
        logic [1:0] pcs;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       mds;
        logic [1:0] mdop;
        logic       busy;
        logic       hi;
        logic       lo;
    } exp_t;

    exp_t sb[$];

    pl_cu #(.MUL_CYCLES(4), .DIV_CYCLES(6)) dut (
        .clock(clock), .resetn(resetn), .op(op), .func(func), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .is_zero(is_zero), .EXE_wreg(EXE_wreg), .EXE_m2reg(EXE_m2reg), .EXE_rn(EXE_rn),
        .MEM_wreg(MEM_wreg), .MEM_m2reg(MEM_m2reg), .MEM_rn(MEM_rn),
        .wreg(wreg), .wmem(wmem), .m2reg(m2reg), .shift(shift), .aluimm(aluimm), .sext(sext),
        .regrt(regrt), .jal(jal), .aluc(aluc), .pcsource(pcsource), .stall(stall), .wpcir(wpcir),
        .fwda(fwda), .fwdb(fwdb), .md_start(md_start), .md_op(md_op), .md_busy(md_busy),
        .mfhi(mfhi), .mflo(mflo)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s step=%0d got=%0h expected=%0h", tag, step_no, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic s, input logic w, input logic wm, input logic [3:0] a,
                                input logic [1:0] p, input logic [1:0] fa, input logic [1:0] fb,
                                input logic ms, input logic [1:0] mo, input logic b,
                                input logic hi, input logic lo);
        exp_t e;
        e = '{stall: s, wreg: w, wmem: wm, aluc: a, pcs: p, fa: fa, fb: fb,
              mds: ms, mdop: mo, busy: b, hi: hi, lo: lo};
        return e;
    endfunction

    task automatic step(input logic [5:0] o, input logic [5:0] f, input logic [4:0] rs,
                        input logic [4:0] rt, input logic z,
                        input logic ew, input logic em, input logic [4:0] ern,
                        input logic mw, input logic mm, input logic [4:0] mrn, input exp_t e);
        exp_t x;
        @(negedge clock);
        step_no++;
        op = o; func = f; ID_rs = rs; ID_rt = rt; is_zero = z;
        EXE_wreg = ew; EXE_m2reg = em; EXE_rn = ern;
        MEM_wreg = mw; MEM_m2reg = mm; MEM_rn = mrn;
        sb.push_back(e);
        #1;
        x = sb.pop_front();
        check("stall", {7'd0, stall}, {7'd0, x.stall});
        check("wpcir", {7'd0, wpcir}, {7'd0, ~x.stall});
        check("wreg", {7'd0, wreg}, {7'd0, x.wreg});
        check("wmem", {7'd0, wmem}, {7'd0, x.wmem});
        check("aluc", {4'd0, aluc}, {4'd0, x.aluc});
        check("pcsource", {6'd0, pcsource}, {6'd0, x.pcs});
        check("fwda", {6'd0, fwda}, {6'd0, x.fa});
        check("fwdb", {6'd0, fwdb}, {6'd0, x.fb});
        check("md_start", {7'd0, md_start}, {7'd0, x.mds});
        if (x.mds) check("md_op", {6'd0, md_op}, {6'd0, x.mdop});
        check("md_busy", {7'd0, md_busy}, {7'd0, x.busy});
        check("mfhi", {7'd0, mfhi}, {7'd0, x.hi});
        check("mflo", {7'd0, mflo}, {7'd0, x.lo});
    endtask

    initial begin
        // Reset: sll $0,$0 in ID, nothing downstream
        step(6'h00, 6'b000000, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd0,
             mk(0, 1, 0, 4'b0011, 0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clock);
        resetn = 1'b1;

        // Load-use: EXE lw $5, ID add $6,$5,$7
        step(6'h00, 6'b100000, 5'd5, 5'd7, 0, 1, 1, 5'd5, 0, 0, 5'd0,
             mk(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
`ifdef CU_FORWARD_EN
        step(6'h00, 6'b100000, 5'd5, 5'd7, 0, 0, 0, 5'd0, 1, 1, 5'd5,
             mk(0, 1, 0, 4'b0000, 0, 3, 0, 0, 0, 0, 0, 0));
        step(6'h00, 6'b100010, 5'd3, 5'd9, 0, 1, 0, 5'd3, 1, 0, 5'd3,
             mk(0, 1, 0, 4'b0100, 0, 1, 0, 0, 0, 0, 0, 0));
`else
        step(6'h00, 6'b100000, 5'd5, 5'd7, 0, 0, 0, 5'd0, 1, 1, 5'd5,
             mk(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        step(6'h00, 6'b100010, 5'd3, 5'd9, 0, 1, 0, 5'd3, 1, 0, 5'd3,
             mk(1, 0, 0, 4'b0100, 0, 0, 0, 0, 0, 0, 0, 0));
`endif
        // beq taken, then squashed sw, then live sw
        step(6'b000100, 6'h00, 5'd1, 5'd2, 1, 0, 0, 5'd0, 0, 0, 5'd0,
             mk(0, 0, 0, 4'b0100, 1, 0, 0, 0, 0, 0, 0, 0));
        step(6'b101011, 6'h00, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, 5'd0,
             mk(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        step(6'b101011, 6'h00, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, 5'd0,
             mk(0, 0, 1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        // bne with equal operands: not taken
        step(6'b000101, 6'h00, 5'd1, 5'd2, 1, 0, 0, 5'd0, 0, 0, 5'd0,
             mk(0, 0, 0, 4'b0100, 0, 0, 0, 0, 0, 0, 0, 0));
        // j, then a mult squashed behind it must not launch the MDU
        step(6'b000010, 6'h00, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd0,
             mk(0, 0, 0, 4'b0000, 3, 0, 0, 0, 0, 0, 0, 0));
        step(6'h00, 6'b011000, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, 5'd0,
             mk(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        // mult launches at T; mflo stalls T+1..T+4, proceeds at T+5
        step(6'h00, 6'b011000, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, 5'd0,
             mk(0, 0, 0, 4'b0000, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            step(6'h00, 6'b010010, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd0,
                 mk(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 0, 1));
        step(6'h00, 6'b010010, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd0,
             mk(0, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1));
        // div launch, mfhi stalled, then reset mid-BUSY
        step(6'h00, 6'b011010, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, 5'd0,
             mk(0, 0, 0, 4'b0000, 0, 0, 0, 1, 2, 0, 0, 0));
        step(6'h00, 6'b010000, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd0,
             mk(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 1, 0));
        #1 resetn = 1'b0;
        #1;
        check("rst_md_busy", {7'd0, md_busy}, 8'd0);
        check("rst_stall", {7'd0, stall}, 8'd0);
        @(negedge clock);
        resetn = 1'b1;
        step(6'h00, 6'b010000, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd0,
             mk(0, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 1, 0));
        // Writes to $0 never stall or forward
        step(6'h00, 6'b100000, 5'd0, 5'd0, 0, 1, 1, 5'd0, 1, 0, 5'd0,
             mk(0, 1, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        // cont
        step(6'h00, 6'b000001, 5'd1, 5'd2, 0, 0, 0, 5'd0, 0, 0, 5'd0,
             mk(0, 1, 0, 4'b1000, 0, 0, 0, 0, 0, 0, 0, 0));
        // jal, squashed add, jr, squashed lui, live lui
        step(6'b000011, 6'h00, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd0,
             mk(0, 1, 0, 4'b0000, 3, 0, 0, 0, 0, 0, 0, 0));
        step(6'h00, 6'b100000, 5'd2, 5'd3, 0, 0, 0, 5'd0, 0, 0, 5'd0,
             mk(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0));
        step(6'h00, 6'b001000, 5'd31, 5'd0, 0, 0, 0, 5'd0, 0, 0, 5'd0,
             mk(0, 0, 0, 4'b0000, 2, 0, 0, 0, 0, 0, 0, 0));
        step(6'b001111, 6'h00, 5'd0, 5'd4, 0, 0, 0, 5'd0, 0, 0, 5'd0,
             mk(0, 0, 0, 4'b0110, 0, 0, 0, 0, 0, 0, 0, 0));
        step(6'b001111, 6'h00, 5'd0, 5'd4, 0, 0, 0, 5'd0, 0, 0, 5'd0,
             mk(0, 1, 0, 4'b0110, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
